dvi_timing_detect: RTL

// Sink-side counterpart of dvi_stimulate: consumes hsync/vsync/ve on the same clock, measures line/frame

---
 rtl/dvi_timing_detect.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dvi_timing_detect.sv
// dvi_timing_detect: sink-side DVI timing detector. Measures line and frame
// timing from hsync/vsync/ve, locks once two consecutive frames agree, then
// emits per-pixel coordinates and flags deviations from the locked timing.
// Optional feature macro: DVI_DETECT_ERRCNT_EN (saturating timing_err counter
// on err_count; when undefined err_count is tied to zero).
module dvi_timing_detect #(
  parameter int CW       = 12,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int IDLE_MAX = 4095
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          ve_in,
  output logic          pixel_valid,
  output logic [CW-1:0] x_pos,
  output logic [CW-1:0] y_pos,
  output logic          line_start,
  output logic          frame_start,
  output logic          locked,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic          timing_err,
  output logic [15:0]   err_count
);

  localparam int            IW   = $clog2(IDLE_MAX + 1);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  state_t        state, state_nxt;
  logic          hs_act, vs_act, hs_prev, vs_prev, hs_edge, vs_edge;
  logic [CW-1:0] hcnt, acnt, lcnt, alcnt, last_h, last_a;
  logic [CW-1:0] cand_h, cand_a, cand_l, cand_al;
  logic [CW-1:0] meas_h, meas_a, frame_l, frame_a, cand_l_new, cand_al_new;
  logic [CW-1:0] x_nxt, y_nxt, x_eff, y_eff;
  logic [IW-1:0] idle_cnt;
  logic          line_has_ve, line_bad, frame_bad, cand_match, timeout;
  logic          cand_ld, out_ld, err_now;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    return (en && v != CMAX) ? v + CW'(1) : v;
  endfunction

  assign hs_act  = (hsync_in == HS_POL);
  assign vs_act  = (vsync_in == VS_POL);
  assign hs_edge = hs_act && !hs_prev;
  assign vs_edge = vs_act && !vs_prev;

  // A line closed on a coincident vsync edge still belongs to the old frame,
  // so the frame totals seen at a vsync edge already include this hsync edge.
  assign line_has_ve = (acnt != '0);
  assign frame_l     = sat_inc(lcnt, hs_edge);
  assign frame_a     = sat_inc(alcnt, hs_edge && line_has_ve);
  // Blanking lines carry no ve, so h_active tracks the last line that had any.
  assign meas_h      = hs_edge ? hcnt : last_h;
  assign meas_a      = (hs_edge && line_has_ve) ? acnt : last_a;
  // A line-only mismatch keeps the frame part of the candidate at locked values.
  assign cand_l_new  = vs_edge ? frame_l : v_total;
  assign cand_al_new = vs_edge ? frame_a : v_active;

  assign line_bad   = hs_edge && (hcnt != h_total || (line_has_ve && acnt != h_active));
  assign frame_bad  = vs_edge && (frame_l != v_total || frame_a != v_active);
  assign cand_match = (meas_h == cand_h) && (meas_a == cand_a) &&
                      (frame_l == cand_l) && (frame_a == cand_al);
  assign timeout    = (idle_cnt == IW'(IDLE_MAX)) && !hs_edge;

  assign x_eff = hs_edge ? '0 : x_nxt;
  assign y_eff = vs_edge ? '0 : sat_inc(y_nxt, hs_edge && line_has_ve);

  // Sync history plus line, frame and idle counters.
  // NOTE: every sequential block uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev  <= 1'b0;
      vs_prev  <= 1'b0;
      hcnt     <= '0;
      acnt     <= '0;
      last_h   <= '0;
      last_a   <= '0;
      lcnt     <= '0;
      alcnt    <= '0;
      idle_cnt <= '0;
    end else begin
      hs_prev <= hs_act;
      vs_prev <= vs_act;
      if (hs_edge) begin
        hcnt     <= CW'(1);
        acnt     <= ve_in ? CW'(1) : '0;
        last_h   <= hcnt;
        last_a   <= meas_a;
        idle_cnt <= '0;
      end else begin
        hcnt <= sat_inc(hcnt, 1'b1);
        acnt <= sat_inc(acnt, ve_in);
        if (idle_cnt != IW'(IDLE_MAX)) idle_cnt <= idle_cnt + IW'(1);
      end
      lcnt  <= vs_edge ? '0 : frame_l;
      alcnt <= vs_edge ? '0 : frame_a;
    end
  end

  // Pixel coordinates, registered alongside pixel_valid and the sync pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pixel_valid <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      x_nxt       <= '0;
      y_nxt       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_valid <= ve_in;
      line_start  <= hs_edge;
      frame_start <= vs_edge;
      x_nxt       <= ve_in ? sat_inc(x_eff, 1'b1) : x_eff;
      y_nxt       <= y_eff;
      if (ve_in) begin
        x_pos <= x_eff;
        y_pos <= y_eff;
      end else begin
        if (hs_edge) x_pos <= '0;
        if (vs_edge) y_pos <= '0;
      end
    end
  end

  // Lock FSM next-state and control decode; timeout overrides everything.
  // NOTE: all outputs get a default first so no path leaves them unassigned,
  // which would otherwise infer latches.
  always_comb begin
    state_nxt = state;
    cand_ld   = 1'b0;
    out_ld    = 1'b0;
    err_now   = 1'b0;
    case (state)
      SEARCH:  if (vs_edge) state_nxt = MEASURE;
      MEASURE: if (vs_edge) begin
                 cand_ld   = 1'b1;
                 state_nxt = VERIFY;
               end
      VERIFY:  if (vs_edge) begin
                 if (cand_match) begin
                   out_ld    = 1'b1;
                   state_nxt = LOCKED;
                 end else begin
                   cand_ld = 1'b1;
                 end
               end
      LOCKED:  if (line_bad || frame_bad) begin
                 err_now   = 1'b1;
                 cand_ld   = 1'b1;
                 state_nxt = VERIFY;
               end
      default: state_nxt = SEARCH;
    endcase
    if (timeout) begin
      state_nxt = SEARCH;
      cand_ld   = 1'b0;
      out_ld    = 1'b0;
      err_now   = 1'b0;
    end
  end

  // FSM state, candidate and locked measurement registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SEARCH;
      locked     <= 1'b0;
      timing_err <= 1'b0;
      cand_h     <= '0;
      cand_a     <= '0;
      cand_l     <= '0;
      cand_al    <= '0;
      h_total    <= '0;
      h_active   <= '0;
      v_total    <= '0;
      v_active   <= '0;
    end else begin
      state      <= state_nxt;
      locked     <= (state_nxt == LOCKED);
      timing_err <= err_now;
      if (cand_ld) begin
        cand_h  <= meas_h;
        cand_a  <= meas_a;
        cand_l  <= cand_l_new;
        cand_al <= cand_al_new;
      end
      if (out_ld) begin
        h_total  <= meas_h;
        h_active <= meas_a;
        v_total  <= frame_l;
        v_active <= frame_a;
      end
    end
  end

`ifdef DVI_DETECT_ERRCNT_EN
  // Saturating count of timing errors, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                             err_count <= '0;
    else if (err_now && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule
